int_res_addr_seq: RTL and testbench
===================================

// Module: int_res_addr_seq
// PURPOSE
//  Parametrised address sequencer for the banked intermediate-result CiM memory.
//  Holds a run-time programmable region base table (successor to the fixed mem_map constants).
//  Turns a (region, offset, length, stride, width) vector request into a stream of (bank, bank_addr, half) words.
//  Sits between the inference controller and the int-res MemoryInterface banks.
// PARAMETERS
//  NUM_BANKS     4      number of int-res banks
//  BANK_DEPTH    14336  words per bank
//  NUM_REGIONS   19     entries in the base table (one per DataStep_t)
//  MAX_LEN       64     max elements per request (VECTOR_MAX_LEN)
//  MAX_STRIDE    64     max element stride in words; must satisfy 2*MAX_STRIDE < BANK_DEPTH
//  DEFAULT_BASE  '{..}  NUM_REGIONS x flat-address reset values for the base table
// PORTS
//  clk           in   1                    clock
//  rst           in   1                    synchronous active-high reset
//  cfg_we        in   1                    write base table entry
//  cfg_region    in   $clog2(NUM_REGIONS)  entry index
//  cfg_base      in   FLAT_W               new flat base address
//  req_valid     in   1                    vector request valid
//  req_ready     out  1                    sequencer idle, request accepted on valid&ready
//  req_region    in   $clog2(NUM_REGIONS)  region select
//  req_offset    in   FLAT_W               word offset from region base
//  req_len       in   $clog2(MAX_LEN+1)    element count (0 legal)
//  req_stride    in   $clog2(MAX_STRIDE+1) element stride in elements
//  req_width     in   1                    DataWidth_t: SINGLE_WIDTH / DOUBLE_WIDTH
//  abort         in   1                    drop current request
//  addr_valid    out  1                    output word valid
//  addr_ready    in   1                    downstream accepts word
//  addr_bank     out  $clog2(NUM_BANKS)    bank select
//  addr_bank_addr out $clog2(BANK_DEPTH)   address within bank
//  addr_half     out  1                    HalfSelect_t for double-width words
//  addr_last     out  1                    final word of request
//  done          out  1                    1-cycle pulse: request finished normally
//  err_oob       out  1                    1-cycle pulse: address past NUM_BANKS*BANK_DEPTH-1
// BEHAVIOUR
//  Always decided: one clock; reset is synchronous and active-high; ports named clk and rst.
//  FLAT_W = $clog2(NUM_BANKS*BANK_DEPTH).
//  Reset: table <= DEFAULT_BASE; state IDLE; req_ready=1; all other outputs 0.
//  Config: cfg_we writes table at next edge; never stalls. A request samples the base at accept;
//   same-cycle cfg write to the same region is not visible to that request.
//  Element address: flat(i) = base + offset + W*i*stride, W=1 single, W=2 double.
//   Double emits two words: flat(i) with half=FIRST_HALF, flat(i)+1 with half=SECOND_HALF.
//  FSM IDLE -> SPLIT -> EMIT -> IDLE:
//   IDLE:  req_ready=1. Accept: latch fields, flat0=base+offset. len==0 -> done pulse next cycle, stay IDLE.
//   SPLIT: one cycle; bank/bank_addr from a compare chain against k*BANK_DEPTH. No divider.
//          flat0 >= NUM_BANKS*BANK_DEPTH (or base+offset overflows FLAT_W) -> err_oob, IDLE.
//   EMIT:  addr_valid=1; outputs hold stable while addr_valid & !addr_ready.
//          On handshake advance incrementally: bank_addr += step; if >= BANK_DEPTH, subtract BANK_DEPTH
//          and bank++. One subtraction always suffices.
//          If bank would reach NUM_BANKS -> err_oob pulse, no further words, IDLE.
//          addr_last=1 on the final word (SECOND_HALF of last element for double).
//          Handshake on last -> done pulse, IDLE.
//  Latency: accept at cycle 0 -> first addr_valid at cycle 2. One word per cycle with no backpressure.
//  abort: highest priority in any state. Next edge -> IDLE, addr_valid=0, no done, no err.
//  done and err_oob are mutually exclusive per request.
// STRUCTURE
//  Shared package: FlatAddr_t, BankIdx_t, BankAddr_t, the SeqState_t enum, and the default base
//   table constant. Reuse DataWidth_t, HalfSelect_t, DataStep_t and VectorLen_t.
//  One sub-module: int_res_bank_split. Combinational flat->(bank, bank_addr, oob), shared by SPLIT.
// TESTING (NUM_BANKS=4, BANK_DEPTH=14336, default table)
//  1. Region ENC_LN1 (base 20000), offset 0, len 3, stride 1, single
//     -> (1,5664) (1,5665) (1,5666); last on third; done.
//  2. cfg base 14330, len 8, stride 1, single
//     -> bank0 14330..14335 then bank1 0,1; no gap across the bank crossing.
//  3. base 100, len 2, stride 4, double
//     -> (0,100,F) (0,101,S) (0,108,F) (0,109,S); last on fourth.
//  4. base 57340, len 8, stride 1
//     -> 57340..57343 emitted, then err_oob pulse; no done; req_ready=1.
//  5. Random addr_ready toggling on case 2
//     -> identical word sequence; outputs stable while stalled.
//  6. abort on the 3rd word of case 2 -> IDLE next cycle, no done.
//     Then len=0 request -> done only, no addr_valid.
//     Reset mid-EMIT -> all outputs 0, table reverts to defaults.

Source files
------------

// File: rtl/int_res_addr_seq_pkg.sv
// Shared types and constants for the intermediate-result address sequencer.
//   FlatAddr_t / BankIdx_t / BankAddr_t : flat, bank-select and in-bank address types
//   DataWidth_t / HalfSelect_t          : element width and word-half select
//   DataStep_t                          : inference step, one base-table entry per step
//   SeqState_t                          : sequencer FSM states
//   DEFAULT_BASE_TABLE                  : reset contents of the region base table
package int_res_addr_seq_pkg;

   localparam int NUM_BANKS_DEF   = 4;
   localparam int BANK_DEPTH_DEF  = 14336;
   localparam int NUM_REGIONS_DEF = 19;
   localparam int MAX_LEN_DEF     = 64;
   localparam int MAX_STRIDE_DEF  = 64;

   localparam int FLAT_W  = $clog2(NUM_BANKS_DEF * BANK_DEPTH_DEF);
   localparam int BANK_W  = $clog2(NUM_BANKS_DEF);
   localparam int BADDR_W = $clog2(BANK_DEPTH_DEF);
   localparam int VLEN_W  = $clog2(MAX_LEN_DEF + 1);

   typedef logic [FLAT_W-1:0]  FlatAddr_t;
   typedef logic [BANK_W-1:0]  BankIdx_t;
   typedef logic [BADDR_W-1:0] BankAddr_t;
   typedef logic [VLEN_W-1:0]  VectorLen_t;

   typedef enum logic {SINGLE_WIDTH = 1'b0, DOUBLE_WIDTH = 1'b1} DataWidth_t;
   typedef enum logic {FIRST_HALF = 1'b0, SECOND_HALF = 1'b1} HalfSelect_t;

   typedef enum logic [4:0] {
      ENC_EMB, ENC_LN0, ENC_Q, ENC_K, ENC_V, ENC_QK, ENC_SOFTMAX, ENC_ATTN_V,
      ENC_ATTN_OUT, ENC_RES0, ENC_LN1, ENC_MLP_IN, ENC_MLP_ACT, ENC_MLP_OUT,
      ENC_RES1, MLP_HEAD_LN, MLP_HEAD_IN, MLP_HEAD_ACT, MLP_HEAD_OUT
   } DataStep_t;

   typedef enum logic [1:0] {ST_IDLE, ST_SPLIT, ST_EMIT} SeqState_t;

   typedef FlatAddr_t [NUM_REGIONS_DEF-1:0] BaseTable_t;

   // Regions are laid out on a 3000-word pitch; ENC_LN1 keeps its legacy base.
   function automatic BaseTable_t default_base_table();
      BaseTable_t t;
      for (int r = 0; r < NUM_REGIONS_DEF; r++) t[r] = FlatAddr_t'(r * 3000);
      t[int'(ENC_LN1)] = FlatAddr_t'(20000);
      return t;
   endfunction

   localparam BaseTable_t DEFAULT_BASE_TABLE = default_base_table();

endpackage

// File: rtl/int_res_addr_seq_bank_split.sv
// Flat address -> (bank, bank_addr) using a compare chain against k*BANK_DEPTH.
//   flat      in  IN_W     flat address (may be wider than the memory range)
//   bank      out          bank holding the address
//   bank_addr out          address within that bank
//   oob       out          flat is at or beyond NUM_BANKS*BANK_DEPTH
module int_res_bank_split #(
   parameter int NUM_BANKS  = 4,
   parameter int BANK_DEPTH = 14336,
   parameter int IN_W       = 17
) (
   input  logic [IN_W-1:0]               flat,
   output logic [$clog2(NUM_BANKS)-1:0]  bank,
   output logic [$clog2(BANK_DEPTH)-1:0] bank_addr,
   output logic                          oob
);

   localparam int BANK_W  = $clog2(NUM_BANKS);
   localparam int BADDR_W = $clog2(BANK_DEPTH);

   // First bank whose upper bound exceeds flat wins; no match means out of range.
   always_comb begin
      bank      = '0;
      bank_addr = '0;
      oob       = 1'b1;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (oob && (flat < IN_W'((k + 1) * BANK_DEPTH))) begin
            oob       = 1'b0;
            bank      = BANK_W'(k);
            bank_addr = BADDR_W'(flat - IN_W'(k * BANK_DEPTH));
         end
      end
   end

endmodule

// File: rtl/int_res_addr_seq.sv
// Address sequencer for the banked intermediate-result memory. Holds a programmable
// region base table and expands a vector request into (bank, bank_addr, half) words.
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we/cfg_region/cfg_base      base table write port
//   req_*                           vector request (valid/ready handshake)
//   abort                           drop the current request
//   addr_*                          output word stream (valid/ready handshake)
//   done / err_oob                  1-cycle completion / out-of-range pulses
//
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_SPLIT | first flat address being split into bank / bank_addr
// ST_EMIT  | words presented on addr_*, advancing on each handshake
module int_res_addr_seq
   import int_res_addr_seq_pkg::*;
#(
   parameter int NUM_BANKS   = NUM_BANKS_DEF,
   parameter int BANK_DEPTH  = BANK_DEPTH_DEF,
   parameter int NUM_REGIONS = NUM_REGIONS_DEF,
   parameter int MAX_LEN     = MAX_LEN_DEF,
   parameter int MAX_STRIDE  = MAX_STRIDE_DEF,
   parameter logic [NUM_REGIONS-1:0][$clog2(NUM_BANKS*BANK_DEPTH)-1:0] DEFAULT_BASE = DEFAULT_BASE_TABLE
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfg_we,
   input  logic [$clog2(NUM_REGIONS)-1:0]         cfg_region,
   input  logic [$clog2(NUM_BANKS*BANK_DEPTH)-1:0] cfg_base,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic [$clog2(NUM_REGIONS)-1:0]         req_region,
   input  logic [$clog2(NUM_BANKS*BANK_DEPTH)-1:0] req_offset,
   input  logic [$clog2(MAX_LEN+1)-1:0]           req_len,
   input  logic [$clog2(MAX_STRIDE+1)-1:0]        req_stride,
   input  logic                                   req_width,
   input  logic                                   abort,
   output logic                                   addr_valid,
   input  logic                                   addr_ready,
   output logic [$clog2(NUM_BANKS)-1:0]           addr_bank,
   output logic [$clog2(BANK_DEPTH)-1:0]          addr_bank_addr,
   output logic                                   addr_half,
   output logic                                   addr_last,
   output logic                                   done,
   output logic                                   err_oob
);

   localparam int FLAT_W  = $clog2(NUM_BANKS * BANK_DEPTH);
   localparam int REG_W   = $clog2(NUM_REGIONS);
   localparam int LEN_W   = $clog2(MAX_LEN + 1);
   localparam int STR_W   = $clog2(MAX_STRIDE + 1);
   localparam int BANK_W  = $clog2(NUM_BANKS);
   localparam int BADDR_W = $clog2(BANK_DEPTH);
   localparam int STEP_W  = STR_W + 1;
   localparam int WORDS_W = LEN_W + 1;

   localparam logic [BADDR_W:0] DEPTH_X = (BADDR_W + 1)'(BANK_DEPTH);
   localparam logic [BANK_W:0]  NBANK_X = (BANK_W + 1)'(NUM_BANKS);

   logic [FLAT_W-1:0]  base_tbl [NUM_REGIONS];
   logic [FLAT_W-1:0]  base_sel;

   SeqState_t          state;
   DataWidth_t         width_q;
   logic [FLAT_W:0]    flat0;
   logic [STEP_W-1:0]  step_q;
   logic [WORDS_W-1:0] words_left;
   logic [BANK_W-1:0]  elem_bank;
   logic [BADDR_W-1:0] elem_addr;

   logic [BANK_W-1:0]  split_bank;
   logic [BADDR_W-1:0] split_addr;
   logic               split_oob;

   logic               in_first_half;
   logic [STEP_W-1:0]  adv_inc;
   logic [BADDR_W:0]   adv_sum;
   logic [BANK_W:0]    adv_bank;
   logic [BADDR_W-1:0] adv_addr;
   logic               adv_oob;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGIONS; r++) base_tbl[r] <= DEFAULT_BASE[r];
      end else if (cfg_we) begin
         for (int r = 0; r < NUM_REGIONS; r++)
            if (cfg_region == REG_W'(r)) base_tbl[r] <= cfg_base;
      end
   end

   // Read the pre-edge table so a same-cycle write is not seen by the accepting request.
   always_comb begin
      base_sel = '0;
      for (int r = 0; r < NUM_REGIONS; r++)
         if (req_region == REG_W'(r)) base_sel = base_tbl[r];
   end

   int_res_bank_split #(
      .NUM_BANKS  (NUM_BANKS),
      .BANK_DEPTH (BANK_DEPTH),
      .IN_W       (FLAT_W + 1)
   ) u_split (
      .flat      (flat0),
      .bank      (split_bank),
      .bank_addr (split_addr),
      .oob       (split_oob)
   );

   // elem_* tracks the first word of the current element, so the second half of a
   // double-width element is elem+1 and the next element is elem+2*stride. This keeps
   // the increment non-negative even for stride 0.
   always_comb begin
      in_first_half = (width_q == DOUBLE_WIDTH) && (addr_half == FIRST_HALF);
      adv_inc       = in_first_half ? STEP_W'(1) : step_q;
      adv_sum       = {1'b0, elem_addr} + (BADDR_W + 1)'(adv_inc);
      adv_bank      = {1'b0, elem_bank};
      adv_addr      = adv_sum[BADDR_W-1:0];
      if (adv_sum >= DEPTH_X) begin
         adv_addr = BADDR_W'(adv_sum - DEPTH_X);
         adv_bank = adv_bank + (BANK_W + 1)'(1);
      end
      adv_oob = (adv_bank >= NBANK_X);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         req_ready      <= 1'b1;
         addr_valid     <= 1'b0;
         addr_bank      <= '0;
         addr_bank_addr <= '0;
         addr_half      <= FIRST_HALF;
         addr_last      <= 1'b0;
         done           <= 1'b0;
         err_oob        <= 1'b0;
         width_q        <= SINGLE_WIDTH;
         flat0          <= '0;
         step_q         <= '0;
         words_left     <= '0;
         elem_bank      <= '0;
         elem_addr      <= '0;
      end else begin
         done    <= 1'b0;
         err_oob <= 1'b0;
         if (abort) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (req_valid) begin
                     width_q    <= DataWidth_t'(req_width);
                     flat0      <= {1'b0, base_sel} + {1'b0, req_offset};
                     step_q     <= req_width ? {req_stride, 1'b0} : {1'b0, req_stride};
                     words_left <= req_width ? {req_len, 1'b0} : {1'b0, req_len};
                     if (req_len == '0) begin
                        done <= 1'b1;
                     end else begin
                        state     <= ST_SPLIT;
                        req_ready <= 1'b0;
                     end
                  end
               end
               ST_SPLIT: begin
                  if (split_oob) begin
                     err_oob   <= 1'b1;
                     state     <= ST_IDLE;
                     req_ready <= 1'b1;
                  end else begin
                     addr_bank      <= split_bank;
                     addr_bank_addr <= split_addr;
                     elem_bank      <= split_bank;
                     elem_addr      <= split_addr;
                     addr_half      <= FIRST_HALF;
                     addr_last      <= (words_left == WORDS_W'(1));
                     addr_valid     <= 1'b1;
                     state          <= ST_EMIT;
                  end
               end
               ST_EMIT: begin
                  if (addr_ready) begin
                     if (addr_last) begin
                        done       <= 1'b1;
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                     end else if (adv_oob) begin
                        err_oob    <= 1'b1;
                        addr_valid <= 1'b0;
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                     end else begin
                        addr_bank      <= adv_bank[BANK_W-1:0];
                        addr_bank_addr <= adv_addr;
                        if (!in_first_half) begin
                           elem_bank <= adv_bank[BANK_W-1:0];
                           elem_addr <= adv_addr;
                        end
                        if (width_q == DOUBLE_WIDTH) addr_half <= ~addr_half;
                        words_left <= words_left - WORDS_W'(1);
                        addr_last  <= (words_left == WORDS_W'(2));
                     end
                  end
               end
               default: begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_int_res_addr_seq.sv
module tb_int_res_addr_seq;
   import int_res_addr_seq_pkg::*;

   localparam int NB    = 4;
   localparam int DEPTH = 14336;
   localparam int NREG  = 19;
   localparam int TOTAL = NB * DEPTH;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_region;
   logic [15:0] cfg_base;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_region;
   logic [15:0] req_offset;
   logic [6:0]  req_len;
   logic [6:0]  req_stride;
   logic        req_width;
   logic        abort;
   logic        addr_valid;
   logic        addr_ready;
   logic [1:0]  addr_bank;
   logic [13:0] addr_bank_addr;
   logic        addr_half;
   logic        addr_last;
   logic        done;
   logic        err_oob;

   int_res_addr_seq dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_region(cfg_region), .cfg_base(cfg_base),
      .req_valid(req_valid), .req_ready(req_ready), .req_region(req_region),
      .req_offset(req_offset), .req_len(req_len), .req_stride(req_stride),
      .req_width(req_width), .abort(abort),
      .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_bank(addr_bank),
      .addr_bank_addr(addr_bank_addr), .addr_half(addr_half), .addr_last(addr_last),
      .done(done), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int model_tbl [NREG];

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic int unsigned pack_word(input int bank, input int addr, input int half, input int last);
      return (bank << 16) | (addr << 2) | (half << 1) | last;
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < NREG; r++) model_tbl[r] = r * 3000;
      model_tbl[int'(ENC_LN1)] = 20000;
   endfunction

   task automatic cfg_write(input int region, input int val);
      cfg_we     = 1'b1;
      cfg_region = 5'(region);
      cfg_base   = 16'(val);
      @(negedge clk);
      cfg_we = 1'b0;
      model_tbl[region] = val;
   endtask

   // Entered and left on a falling edge. abort_word < 0 means no abort.
   task automatic run_req(input int region, input int offset, input int len, input int stride,
                          input bit dbl, input int stall_pct, input int abort_word,
                          input bit cfg_same, input int cfg_val);
      int unsigned exp_words [$];
      bit  exp_err;
      bit  seen_end;
      int  w, f, n, got, first_n;

      exp_err = 1'b0;
      w = dbl ? 2 : 1;
      for (int i = 0; i < len && !exp_err; i++) begin
         for (int h = 0; h < w && !exp_err; h++) begin
            f = model_tbl[region] + offset + w * i * stride + h;
            if (f >= TOTAL) exp_err = 1'b1;
            else exp_words.push_back(pack_word(f / DEPTH, f % DEPTH, h,
                                               (i == len - 1 && h == w - 1) ? 1 : 0));
         end
      end

      check("req_ready_before_accept", 32'(req_ready), 1);
      req_valid  = 1'b1;
      req_region = 5'(region);
      req_offset = 16'(offset);
      req_len    = 7'(len);
      req_stride = 7'(stride);
      req_width  = dbl;
      if (cfg_same) begin
         cfg_we     = 1'b1;
         cfg_region = 5'(region);
         cfg_base   = 16'(cfg_val);
      end
      @(negedge clk);
      req_valid = 1'b0;
      cfg_we    = 1'b0;
      if (cfg_same) model_tbl[region] = cfg_val;

      n = 1; got = 0; first_n = 0; seen_end = 1'b0;
      while (!seen_end && n < 3000) begin
         if (done || err_oob) begin
            seen_end = 1'b1;
            check("done_pulse", 32'(done), exp_err ? 0 : 1);
            check("err_oob_pulse", 32'(err_oob), exp_err ? 1 : 0);
            check("word_count", got, exp_words.size());
            if (stall_pct == 0 && first_n != 0)
               check("no_gap_throughput", n, first_n + exp_words.size());
         end else begin
            addr_ready = ($urandom_range(0, 99) >= stall_pct);
            if (addr_valid) begin
               if (first_n == 0) begin
                  first_n = n;
                  check("first_word_latency", n, 2);
               end
               if (got < exp_words.size())
                  check("word", pack_word(int'(addr_bank), int'(addr_bank_addr),
                                         int'(addr_half), int'(addr_last)), exp_words[got]);
               else
                  check("extra_word", got, exp_words.size());
               if (got == abort_word) begin
                  abort      = 1'b1;
                  addr_ready = 1'b0;
                  @(negedge clk);
                  abort = 1'b0;
                  check("abort_valid_low", 32'(addr_valid), 0);
                  check("abort_ready_high", 32'(req_ready), 1);
                  for (int k = 0; k < 3; k++) begin
                     check("abort_no_pulse", 32'(done | err_oob), 0);
                     @(negedge clk);
                  end
                  return;
               end
               if (addr_ready) got++;
            end
            @(negedge clk);
            n++;
         end
      end
      check("request_finished_in_budget", 32'(seen_end), 1);
      addr_ready = 1'b0;
      @(negedge clk);
      check("pulse_one_cycle", 32'(done | err_oob), 0);
      check("idle_valid_low", 32'(addr_valid), 0);
      check("idle_ready_high", 32'(req_ready), 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: observed timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int region, offset, len, stride, stall;
      bit dbl, same;

      rst = 1'b1; cfg_we = 1'b0; cfg_region = '0; cfg_base = '0;
      req_valid = 1'b0; req_region = '0; req_offset = '0; req_len = '0;
      req_stride = '0; req_width = 1'b0; abort = 1'b0; addr_ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 1);
      check("reset_addr_valid", 32'(addr_valid), 0);
      check("reset_done", 32'(done), 0);
      check("reset_err_oob", 32'(err_oob), 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: ENC_LN1 default base
      run_req(int'(ENC_LN1), 0, 3, 1, 1'b0, 0, -1, 1'b0, 0);
      // 2: bank crossing
      cfg_write(0, 14330);
      run_req(0, 0, 8, 1, 1'b0, 0, -1, 1'b0, 0);
      // 3: double width, stride 4
      cfg_write(1, 100);
      run_req(1, 0, 2, 4, 1'b1, 0, -1, 1'b0, 0);
      // 4: runs off the end of the last bank
      cfg_write(18, 57340);
      run_req(18, 0, 8, 1, 1'b0, 0, -1, 1'b0, 0);
      // 5: case 2 under backpressure
      run_req(0, 0, 8, 1, 1'b0, 50, -1, 1'b0, 0);
      // 6: abort on third word, then an empty request
      run_req(0, 0, 8, 1, 1'b0, 0, 2, 1'b0, 0);
      run_req(0, 0, 0, 1, 1'b0, 0, -1, 1'b0, 0);
      // same-cycle config write to the requested region is not seen by that request
      run_req(1, 4, 2, 1, 1'b0, 0, -1, 1'b1, 30000);
      run_req(1, 4, 1, 1, 1'b0, 0, -1, 1'b0, 0);

      // reset in the middle of emission
      req_valid = 1'b1; req_region = 5'd0; req_offset = '0; req_len = 7'd8;
      req_stride = 7'd1; req_width = 1'b0; addr_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_addr_valid", 32'(addr_valid), 0);
      check("midrst_addr_bank", 32'(addr_bank), 0);
      check("midrst_addr_bank_addr", 32'(addr_bank_addr), 0);
      check("midrst_addr_half", 32'(addr_half), 0);
      check("midrst_addr_last", 32'(addr_last), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_err_oob", 32'(err_oob), 0);
      check("midrst_req_ready", 32'(req_ready), 1);
      rst = 1'b0;
      addr_ready = 1'b0;
      model_reset();
      @(negedge clk);
      run_req(0, 5, 1, 1, 1'b0, 0, -1, 1'b0, 0);
      run_req(18, 0, 2, 3, 1'b1, 0, -1, 1'b0, 0);

      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) cfg_write($urandom_range(0, NREG - 1), $urandom_range(0, TOTAL - 1));
         region = $urandom_range(0, NREG - 1);
         offset = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 30000);
         len    = $urandom_range(0, 64);
         stride = $urandom_range(0, 64);
         dbl    = 1'($urandom_range(0, 1));
         stall  = $urandom_range(0, 2) * 30;
         same   = ($urandom_range(0, 4) == 0);
         run_req(region, offset, len, stride, dbl, stall, -1, same, $urandom_range(0, TOTAL - 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
